// File: rtl/lcd_cfah_emulator.sv
// Emulator of an HD44780-compatible character LCD controller: decodes bus writes,
// logs them in a circular buffer, and answers reads with busy/address or a forced byte.
module lcd_cfah_emulator #(
  parameter int G_RECEIVED_CMD_BUFFER_SIZE = 256,
  localparam int AW = $clog2(G_RECEIVED_CMD_BUFFER_SIZE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_rs,
  input  logic          i_rw,
  input  logic          i_en,
  inout  wire  [7:0]    io_data,
  input  logic [7:0]    i_busy_flag_duration,
  input  logic [7:0]    i_wdata,
  input  logic          i_wdata_sel,
  output logic [7:0]    o_rdata,
  output logic          o_rdata_val,
  input  logic [AW-1:0] i_buf_rd_idx,
  output logic [8:0]    o_buf_rd_data,
  output logic [AW:0]   o_buf_count
);

  localparam logic [AW:0] FULL = G_RECEIVED_CMD_BUFFER_SIZE[AW:0];

  logic          en_m, en_s, en_d;
  logic          rs_m, rs_s, rw_m, rw_s;
  logic [7:0]    d_m, d_s;
  logic          sh_rs, sh_rw;
  logic [7:0]    sh_data;
  logic [7:0]    busy_cnt;
  logic [6:0]    ac, next_ac;
  logic [7:0]    drive_val;
  logic [AW-1:0] wr_ptr, oldest, rd_phys;
  logic [AW:0]   count;
  logic [8:0]    mem [G_RECEIVED_CMD_BUFFER_SIZE];
  logic          fall, commit_wr, commit_rd, bf;

  assign fall      = en_d & ~en_s;
  assign commit_wr = fall & ~sh_rw;
  assign commit_rd = fall & sh_rw;
  assign bf        = (busy_cnt != 8'd0);

  // The strobe is asynchronous, so the bus fields travel together through two flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_m    <= 1'b0;
      en_s    <= 1'b0;
      en_d    <= 1'b0;
      rs_m    <= 1'b0;
      rs_s    <= 1'b0;
      rw_m    <= 1'b0;
      rw_s    <= 1'b0;
      d_m     <= 8'd0;
      d_s     <= 8'd0;
      sh_rs   <= 1'b0;
      sh_rw   <= 1'b0;
      sh_data <= 8'd0;
    end else begin
      en_m <= i_en;
      en_s <= en_m;
      en_d <= en_s;
      rs_m <= i_rs;
      rs_s <= rs_m;
      rw_m <= i_rw;
      rw_s <= rw_m;
      d_m  <= io_data;
      d_s  <= d_m;
      if (en_s) begin
        sh_rs   <= rs_s;
        sh_rw   <= rw_s;
        sh_data <= d_s;
      end
    end
  end

  always_comb begin
    next_ac = ac;
    if (sh_rs)
      next_ac = ac + 7'd1;
    else if (sh_data == 8'h01 || sh_data == 8'h02 || sh_data == 8'h03)
      next_ac = 7'd0;
    else if (sh_data[7])
      next_ac = sh_data[6:0];
  end

  // A write commit always reloads the busy counter, even if it is still running.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_rdata     <= 8'd0;
      o_rdata_val <= 1'b0;
      busy_cnt    <= 8'd0;
      ac          <= 7'd0;
      wr_ptr      <= '0;
      count       <= '0;
      drive_val   <= 8'd0;
    end else begin
      o_rdata_val <= commit_wr;
      drive_val   <= i_wdata_sel ? i_wdata : {bf, ac};
      if (commit_wr) begin
        o_rdata  <= sh_data;
        wr_ptr   <= wr_ptr + 1'b1;
        busy_cnt <= i_busy_flag_duration;
        ac       <= next_ac;
        if (count != FULL)
          count <= count + 1'b1;
      end else begin
        if (bf)
          busy_cnt <= busy_cnt - 8'd1;
        if (commit_rd && sh_rs)
          ac <= ac + 7'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && commit_wr)
      mem[wr_ptr] <= {sh_rs, sh_data};
  end

  // Once the buffer has wrapped, the oldest entry sits at the write pointer.
  assign oldest        = (count == FULL) ? wr_ptr : '0;
  assign rd_phys       = oldest + i_buf_rd_idx;
  assign o_buf_rd_data = mem[rd_phys];
  assign o_buf_count   = count;

  assign io_data = (i_en && i_rw && !rst) ? drive_val : 8'bz;

endmodule

// File: tb/tb_lcd_cfah_emulator.sv
// Randomized bench for lcd_cfah_emulator with a queue-based model of the
// received-byte log, last written byte and address counter.
module tb_lcd_cfah_emulator;

  localparam int SIZE = 256;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_rs, i_rw, i_en, i_wdata_sel;
  logic [7:0] i_busy_flag_duration, i_wdata;
  wire  [7:0] io_data;
  logic [7:0] tb_drv;
  logic       tb_oe;
  logic [7:0] o_rdata;
  logic       o_rdata_val;
  logic [7:0] i_buf_rd_idx = 8'd0;
  logic [8:0] o_buf_rd_data;
  logic [8:0] o_buf_count;

  int checks = 0;
  int passes = 0;
  int pulses = 0;
  logic [7:0] pulse_data;
  bit quiet = 1'b0;
  int scan = 0;

  logic [8:0] model_log[$];
  logic [6:0] model_ac;
  logic [7:0] model_rdata;

  always #5 clk = ~clk;

  assign io_data = tb_oe ? tb_drv : 8'bz;

  lcd_cfah_emulator #(.G_RECEIVED_CMD_BUFFER_SIZE(SIZE)) dut (
    .clk(clk),
    .rst(rst),
    .i_rs(i_rs),
    .i_rw(i_rw),
    .i_en(i_en),
    .io_data(io_data),
    .i_busy_flag_duration(i_busy_flag_duration),
    .i_wdata(i_wdata),
    .i_wdata_sel(i_wdata_sel),
    .o_rdata(o_rdata),
    .o_rdata_val(o_rdata_val),
    .i_buf_rd_idx(i_buf_rd_idx),
    .o_buf_rd_data(o_buf_rd_data),
    .o_buf_count(o_buf_count)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp)
      passes++;
    else
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (o_rdata_val) begin
      pulses     <= pulses + 1;
      pulse_data <= o_rdata;
    end
  end

  // Outside transactions, every output must match the model; the log is scanned in rotation.
  always @(negedge clk) begin
    if (quiet) begin
      int idx;
      checkOutput("idle_rdata_val", 32'(o_rdata_val), 32'd0);
      checkOutput("idle_rdata", 32'(o_rdata), 32'(model_rdata));
      checkOutput("idle_count", 32'(o_buf_count), 32'(model_log.size()));
      if (model_log.size() > 0) begin
        idx = scan % model_log.size();
        scan++;
        i_buf_rd_idx = 8'(idx);
        #1;
        checkOutput("log_entry", 32'(o_buf_rd_data), 32'(model_log[idx]));
      end
    end
  end

  task automatic modelCommit(input bit rs, input bit rw, input logic [7:0] d);
    if (!rw) begin
      model_log.push_back({rs, d});
      if (model_log.size() > SIZE)
        void'(model_log.pop_front());
      model_rdata = d;
      if (rs)
        model_ac = model_ac + 7'd1;
      else if (d == 8'h01 || d == 8'h02 || d == 8'h03)
        model_ac = 7'd0;
      else if (d >= 8'h80)
        model_ac = 7'(d - 8'h80);
    end else if (rs) begin
      model_ac = model_ac + 7'd1;
    end
  endtask

  task automatic modelReset();
    model_log.delete();
    model_ac    = 7'd0;
    model_rdata = 8'd0;
  endtask

  // One full bus cycle; starts and ends on a falling clock edge.
  task automatic applyStimulus(input bit rs, input bit rw, input logic [7:0] data,
                               input logic [7:0] dur, output logic [7:0] rd);
    int p0;
    quiet = 1'b0;
    p0 = pulses;
    i_rs = rs;
    i_rw = rw;
    i_busy_flag_duration = dur;
    tb_drv = data;
    tb_oe = !rw;
    i_en = 1'b1;
    repeat (4) @(negedge clk);
    rd = io_data;
    i_en = 1'b0;
    @(negedge clk);
    tb_oe = 1'b0;
    repeat (4) @(negedge clk);
    if (!rw) begin
      checkOutput("write_bus_value", 32'(rd), 32'(data));
      checkOutput("write_pulse_count", 32'(pulses - p0), 32'd1);
      checkOutput("write_pulse_data", 32'(pulse_data), 32'(data));
    end else begin
      checkOutput("read_no_pulse", 32'(pulses - p0), 32'd0);
    end
    modelCommit(rs, rw, data);
    quiet = 1'b1;
  endtask

  task automatic doWrite(input bit rs, input logic [7:0] data, input logic [7:0] dur);
    logic [7:0] rd;
    applyStimulus(rs, 1'b0, data, dur, rd);
  endtask

  task automatic doRead(input bit rs, input bit sel, input logic [7:0] wd, output logic [7:0] rd);
    i_wdata_sel = sel;
    i_wdata = wd;
    applyStimulus(rs, 1'b1, 8'h00, i_busy_flag_duration, rd);
  endtask

  task automatic doReset();
    quiet = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    quiet = 1'b1;
  endtask

  initial begin
    logic [7:0] rd;
    logic [7:0] exp_rd;
    int p0;
    rst = 1'b1;
    i_rs = 1'b0;
    i_rw = 1'b0;
    i_en = 1'b0;
    i_wdata_sel = 1'b0;
    i_wdata = 8'h00;
    i_busy_flag_duration = 8'd0;
    tb_drv = 8'h00;
    tb_oe = 1'b0;
    modelReset();
    @(negedge clk);
    doReset();

    checkOutput("reset_rdata", 32'(o_rdata), 32'h00);
    checkOutput("reset_rdata_val", 32'(o_rdata_val), 32'd0);
    checkOutput("reset_count", 32'(o_buf_count), 32'd0);

    // Bus must be released while idle: a bench pattern reads back unchanged.
    i_wdata_sel = 1'b1;
    i_wdata = 8'hA5;
    i_rw = 1'b1;
    tb_drv = 8'h5A;
    tb_oe = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("idle_bus_released", 32'(io_data), 32'h5A);
    tb_oe = 1'b0;
    i_rw = 1'b0;
    i_wdata_sel = 1'b0;

    doWrite(1'b0, 8'h38, 8'd10);
    checkOutput("model_entry0_038", 32'(model_log[0]), 32'h038);
    doRead(1'b0, 1'b0, 8'h00, rd);
    checkOutput("status_busy", 32'(rd), 32'h80);
    repeat (15) @(negedge clk);
    doRead(1'b0, 1'b0, 8'h00, rd);
    checkOutput("status_idle", 32'(rd), 32'h00);

    doReset();
    doWrite(1'b0, 8'hC5, 8'd2);
    doWrite(1'b1, 8'h41, 8'd2);
    checkOutput("model_entry0_0c5", 32'(model_log[0]), 32'h0C5);
    checkOutput("model_entry1_141", 32'(model_log[1]), 32'h141);
    repeat (5) @(negedge clk);
    doRead(1'b0, 1'b0, 8'h00, rd);
    checkOutput("status_ac_46", 32'(rd), 32'h46);

    doRead(1'b0, 1'b1, 8'hA5, rd);
    checkOutput("forced_read_a5", 32'(rd), 32'hA5);

    doWrite(1'b0, 8'h80, 8'd0);
    doRead(1'b0, 1'b0, 8'h00, rd);
    checkOutput("dur0_no_busy", 32'(rd), 32'h00);

    // Randomized mix of writes and reads; reads only after any busy period has expired.
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) < 7) begin
        doWrite(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 20)));
      end else begin
        bit rs;
        bit sel;
        logic [7:0] wd;
        rs = 1'($urandom_range(0, 1));
        sel = 1'($urandom_range(0, 1));
        wd = 8'($urandom_range(0, 255));
        repeat (25) @(negedge clk);
        exp_rd = sel ? wd : {1'b0, model_ac};
        doRead(rs, sel, wd, rd);
        checkOutput("random_read", 32'(rd), 32'(exp_rd));
      end
    end

    // Reset during a write strobe aborts it; a read strobe under reset leaves the bus free.
    quiet = 1'b0;
    p0 = pulses;
    i_rs = 1'b1;
    i_rw = 1'b0;
    tb_drv = 8'h77;
    tb_oe = 1'b1;
    i_en = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    i_en = 1'b0;
    repeat (2) @(negedge clk);
    i_rw = 1'b1;
    i_en = 1'b1;
    tb_drv = 8'h5A;
    i_wdata_sel = 1'b1;
    i_wdata = 8'hA5;
    repeat (2) @(negedge clk);
    checkOutput("reset_bus_released", 32'(io_data), 32'h5A);
    i_en = 1'b0;
    i_rw = 1'b0;
    tb_oe = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    repeat (8) @(negedge clk);
    checkOutput("reset_abort_no_pulse", 32'(pulses - p0), 32'd0);
    checkOutput("reset_abort_count", 32'(o_buf_count), 32'd0);
    quiet = 1'b1;

    doReset();
    for (int i = 0; i < 258; i++)
      doWrite(1'b0, 8'(i), 8'd0);
    checkOutput("model_wrap_size", 32'(model_log.size()), 32'd256);
    checkOutput("model_wrap_entry0", 32'(model_log[0]), 32'h002);
    checkOutput("model_wrap_entry255", 32'(model_log[255]), 32'h001);
    checkOutput("wrap_count", 32'(o_buf_count), 32'd256);
    repeat (SIZE + 8) @(negedge clk);

    quiet = 1'b0;
    @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/lcd_cfah_emulator.md
Name: lcd_cfah_emulator

Overview:
Behavioural/synthesizable emulator of a Crystalfontz CFAH character LCD controller (HD44780-compatible) for system-level benches. It sits on the 8-bit parallel LCD bus of the LCD driver under test and decodes bus writes. Each written byte is reported on a check interface and logged in a circular buffer. Bus reads return either an autonomous busy flag plus address counter, or a bench-forced byte.

Parameters:
G_RECEIVED_CMD_BUFFER_SIZE, 256, depth of received-byte log; power of two, 2..1024.

Ports:
clk  in  1  single clock, all logic on rising edge.
rst  in  1  synchronous reset, active-high.
i_rs  in  1  register select (0 = command, 1 = data).
i_rw  in  1  1 = read, 0 = write.
i_en  in  1  enable strobe, asynchronous to clk.
io_data  inout  8  LCD data bus.
i_busy_flag_duration  in  8  busy time in clk cycles after each write.
i_wdata  in  8  byte returned on reads when i_wdata_sel = 1.
i_wdata_sel  in  1  0 = autonomous busy/address read; 1 = return i_wdata.
o_rdata  out  8  last byte written by the bus master.
o_rdata_val  out  1  one-cycle pulse when o_rdata updates.
i_buf_rd_idx  in  log2(SIZE)  log read index, 0 = oldest entry.
o_buf_rd_data  out  9  {rs, data} at i_buf_rd_idx, combinational.
o_buf_count  out  log2(SIZE)+1  number of valid log entries, saturating at SIZE.

Behaviour:
- Reset (rst = 1 at a clk edge):
  - o_rdata = 0, o_rdata_val = 0.
  - Busy counter = 0, address counter AC = 0.
  - Log count = 0, write pointer = 0.
  - Synchronizers cleared; io_data released (Z).
- Input synchronization: i_en, i_rs, i_rw and io_data pass through a 2-flop synchronizer. Let en_s, rs_s, rw_s, d_s be the stage-2 outputs.
- Shadow register: every cycle that en_s = 1, store {rs_s, rw_s, d_s}.
- Write commit: on the cycle en_s falls 1 -> 0 with shadow rw = 0:
  - Next edge: o_rdata <= shadow data and o_rdata_val = 1 for exactly one cycle.
  - Log gets {shadow rs, data} at the write pointer. The pointer wraps modulo SIZE; when full, the oldest entry is overwritten and count stays at SIZE.
  - Busy counter <= i_busy_flag_duration, sampled at commit.
  - The commit is accepted even if busy is already set; the counter reloads.
- Busy flag: BF = 1 while busy counter != 0. The counter decrements by 1 per cycle to 0. A duration of 0 means BF is never set.
- Address counter AC (7 bits), updated at write commit:
  - rs = 0, data = 0x01 (clear) or 0x02/0x03 (home): AC <= 0.
  - rs = 0, data[7] = 1: AC <= data[6:0].
  - rs = 1: AC <= AC + 1, wrapping 127 -> 0.
  - All other commands: AC unchanged.
- Read cycle (shadow rw = 1) on en_s fall:
  - No o_rdata_val pulse and no log entry.
  - If rs = 1, AC increments.
- Bus drive:
  - io_data is driven only while raw i_en = 1 and raw i_rw = 1 (combinational output enable); otherwise Z.
  - Driven value is a register updated every cycle: i_wdata_sel = 1 -> i_wdata; else {BF, AC}.
  - The first synchronizer cycles of a read strobe may show a stale value. Masters must hold en at least 3 clk cycles.
- Simultaneous events: a commit in the same cycle the busy counter would reach 0 -> reload wins. Reset mid-strobe -> aborted, no commit, bus released.
- io_data is never driven when i_rw = 0 (no contention with the master).

Test Plan:
- Reset then idle: io_data = Z, o_rdata = 0x00, o_rdata_val = 0, o_buf_count = 0.
- Write rs = 0, data 0x38, duration 10 -> one o_rdata_val pulse with o_rdata = 0x38; entry 0 = 0x038; read with sel = 0 returns 0x80 (BF = 1, AC = 0), and after 10 cycles returns 0x00.
- Write 0xC5 (rs = 0) then data 0x41 (rs = 1) -> entries 0x0C5 and 0x141; status read gives AC = 0x46.
- sel = 1, i_wdata = 0xA5, read strobe -> io_data = 0xA5 during en; no o_rdata_val pulse; count unchanged.
- 258 writes of i[7:0] -> count = 256; entry 0 = 0x002; entry 255 = 0x001.
- Write with duration 0, then status read -> BF = 0 immediately; reset asserted mid-write strobe -> no pulse, no entry.
